io_bus_arbiter: RTL and testbench

- Two-port arbiter and sequencer that shares the single-bit-per-address memory-mapped I/O block between two requesters.
- Port 0 is the CR16 processor's load/store path. Port 1 is the auxiliary game-logic path, e.g. a light-gun/trigger poller or LED/sound driver.
- Each port posts a one-cycle request. The block latches the request, arbitrates round-robin, and drives the I/O block's en/memwrite/memread/adr/writedata for exactly one cycle.
- It captures the registered read data on the following cycle and returns it with a one-cycle ack pulse.

---
 rtl/io_bus_arbiter.sv | 172 +++++++++++++++++
 tb/tb_io_bus_arbiter.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_arbiter.sv
// io_bus_arbiter: two-port round-robin arbiter and sequencer in front of the
// single-bit-per-address I/O block. Each accepted request runs a fixed
// IDLE -> ISSUE -> CAPTURE -> DONE sequence: one strobe cycle on the I/O side,
// one cycle for the I/O block's registered read data, then a one-cycle ack.
module io_bus_arbiter #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [ADDR_BITS-1:0] adr0,
  input  logic [ADDR_BITS-1:0] adr1,
  input  logic [WIDTH-1:0]     wdata0,
  input  logic [WIDTH-1:0]     wdata1,
  output logic                 busy0,
  output logic                 busy1,
  output logic                 ack0,
  output logic                 ack1,
  output logic [WIDTH-1:0]     rdata0,
  output logic [WIDTH-1:0]     rdata1,
  output logic                 io_en,
  output logic                 io_memwrite,
  output logic                 io_memread,
  output logic [ADDR_BITS-1:0] io_adr,
  output logic [WIDTH-1:0]     io_writedata,
  input  logic [WIDTH-1:0]     io_memdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;

  state_t               state_q, state_d;
  logic                 pend0_q, pend1_q;
  logic                 busy0_q, busy1_q;
  logic                 we0_q, we1_q;
  logic [ADDR_BITS-1:0] adr0_q, adr1_q;
  logic [WIDTH-1:0]     wd0_q, wd1_q;
  logic                 gnt_q;     // port currently in service
  logic                 last_q;    // port served most recently
  logic                 io_we_q;
  logic [ADDR_BITS-1:0] io_adr_q;
  logic [WIDTH-1:0]     io_wd_q;
  logic [WIDTH-1:0]     rdata0_q, rdata1_q;

  logic                 accept0, accept1;
  logic                 grant_vld, grant_port;
  logic                 g_we;
  logic [ADDR_BITS-1:0] g_adr;
  logic [WIDTH-1:0]     g_wd;

  // A request is taken only while its port has nothing outstanding.
  assign accept0 = req0 & ~busy0_q;
  assign accept1 = req1 & ~busy1_q;

  // Arbitration: on a tie the port that was not served last wins.
  assign grant_vld  = (state_q == IDLE) & (pend0_q | pend1_q);
  assign grant_port = (pend0_q & pend1_q) ? ~last_q : pend1_q;
  assign g_we       = grant_port ? we1_q  : we0_q;
  assign g_adr      = grant_port ? adr1_q : adr0_q;
  assign g_wd       = grant_port ? wd1_q  : wd0_q;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: fixed four-cycle sequence once a grant is made.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_vld) state_d = ISSUE;
      ISSUE:   state_d = CAPTURE;
      CAPTURE: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: strobes only in ISSUE, ack only in DONE for the granted port.
  always_comb begin
    io_en       = 1'b0;
    io_memwrite = 1'b0;
    io_memread  = 1'b0;
    ack0        = 1'b0;
    ack1        = 1'b0;
    case (state_q)
      ISSUE: begin
        io_en       = 1'b1;
        io_memwrite = io_we_q;
        io_memread  = ~io_we_q;
      end
      DONE: begin
        ack0 = ~gnt_q;
        ack1 = gnt_q;
      end
      default: ;
    endcase
  end

  // Pending and busy flags: busy spans acceptance until the ack cycle ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend0_q <= 1'b0;
      pend1_q <= 1'b0;
      busy0_q <= 1'b0;
      busy1_q <= 1'b0;
    end else begin
      if (accept0)                       pend0_q <= 1'b1;
      else if (grant_vld && !grant_port) pend0_q <= 1'b0;
      if (accept1)                       pend1_q <= 1'b1;
      else if (grant_vld && grant_port)  pend1_q <= 1'b0;
      if (accept0)   busy0_q <= 1'b1;
      else if (ack0) busy0_q <= 1'b0;
      if (accept1)   busy1_q <= 1'b1;
      else if (ack1) busy1_q <= 1'b0;
    end
  end

  // Per-port request slots; contents are only meaningful while pend is set.
  always_ff @(posedge clk) begin
    if (accept0) begin
      we0_q  <= we0;
      adr0_q <= adr0;
      wd0_q  <= wdata0;
    end
    if (accept1) begin
      we1_q  <= we1;
      adr1_q <= adr1;
      wd1_q  <= wdata1;
    end
  end

  // Grant bookkeeping and I/O address/data; these hold outside ISSUE.
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      io_we_q  <= 1'b0;
      io_adr_q <= '0;
      io_wd_q  <= '0;
    end else if (grant_vld) begin
      gnt_q    <= grant_port;
      last_q   <= grant_port;
      io_we_q  <= g_we;
      io_adr_q <= g_adr;
      io_wd_q  <= g_wd;
    end
  end

  // Read data capture at the end of CAPTURE; writes leave rdata untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (state_q == CAPTURE && !io_we_q) begin
      if (gnt_q) rdata1_q <= io_memdata;
      else       rdata0_q <= io_memdata;
    end
  end

  assign busy0        = busy0_q;
  assign busy1        = busy1_q;
  assign rdata0       = rdata0_q;
  assign rdata1       = rdata1_q;
  assign io_adr       = io_adr_q;
  assign io_writedata = io_wd_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Bench for io_bus_arbiter: a bit-per-address I/O model, a per-port scoreboard
// of expected read results, and one task per scenario.
module tb_io_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [15:0] adr0 = '0, adr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        busy0, busy1, ack0, ack1;
  logic [15:0] rdata0, rdata1;
  logic        io_en, io_memwrite, io_memread;
  logic [15:0] io_adr, io_writedata;
  logic [15:0] io_memdata = '0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  io_bus_arbiter #(.WIDTH(16), .ADDR_BITS(16)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .adr0(adr0), .adr1(adr1), .wdata0(wdata0), .wdata1(wdata1),
    .busy0(busy0), .busy1(busy1), .ack0(ack0), .ack1(ack1),
    .rdata0(rdata0), .rdata1(rdata1),
    .io_en(io_en), .io_memwrite(io_memwrite), .io_memread(io_memread),
    .io_adr(io_adr), .io_writedata(io_writedata), .io_memdata(io_memdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // I/O block model: one bit per address, read data registered on the strobe edge.
  logic [31:0] io_bits  = 32'h0000_0020;
  always @(posedge clk) begin
    if (io_en === 1'b1) begin
      if (io_memwrite === 1'b1) io_bits[io_adr[4:0]] <= io_writedata[0];
      io_memdata <= {15'b0, io_bits[io_adr[4:0]]};
    end
  end

  // Scoreboard: expected rdata per port, pushed on stimulus, popped on ack.
  logic [31:0] ref_bits = 32'h0000_0020;
  logic [15:0] rd_hold [2];
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  logic [15:0] e0, e1;

  int ack0_cnt = 0, ack1_cnt = 0, ack0_cyc = 0, ack1_cyc = 0, en_cnt = 0;
  int          en_cyc_log[$];
  logic [15:0] en_adr_log[$];
  logic        en_we_log[$];
  logic [15:0] en_wd_log[$];

  always @(negedge clk) begin
    if (io_en === 1'b1) begin
      en_cnt++;
      en_cyc_log.push_back(cyc);
      en_adr_log.push_back(io_adr);
      en_we_log.push_back(io_memwrite);
      en_wd_log.push_back(io_writedata);
      total++;
      if ((io_memwrite ^ io_memread) !== 1'b1) begin
        bad++;
        $display("FAIL strobes: memwrite=%b memread=%b required exactly one", io_memwrite, io_memread);
      end
    end
    if (ack0 === 1'b1) begin
      ack0_cnt++;
      ack0_cyc = cyc;
      total++;
      if (exp_q0.size() == 0) begin
        bad++;
        $display("FAIL ack0_unexpected: ack0 with no outstanding request at cycle %0d", cyc);
      end else begin
        e0 = exp_q0.pop_front();
        if (rdata0 !== e0) begin
          bad++;
          $display("FAIL rdata0: got %h required %h", rdata0, e0);
        end
      end
    end
    if (ack1 === 1'b1) begin
      ack1_cnt++;
      ack1_cyc = cyc;
      total++;
      if (exp_q1.size() == 0) begin
        bad++;
        $display("FAIL ack1_unexpected: ack1 with no outstanding request at cycle %0d", cyc);
      end else begin
        e1 = exp_q1.pop_front();
        if (rdata1 !== e1) begin
          bad++;
          $display("FAIL rdata1: got %h required %h", rdata1, e1);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_log();
    en_cyc_log.delete();
    en_adr_log.delete();
    en_we_log.delete();
    en_wd_log.delete();
  endtask

  // Record what the port should return when its ack arrives.
  task automatic expect_txn(input int p, input logic we, input logic [15:0] adr,
                            input logic [15:0] wd);
    logic [15:0] e;
    if (we) begin
      ref_bits[adr[4:0]] = wd[0];
      e = rd_hold[p];
    end else begin
      e = {15'b0, ref_bits[adr[4:0]]};
      rd_hold[p] = e;
    end
    if (p == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  // Hold the given requests for one cycle (called just after a rising edge).
  task automatic pulse(input logic r0, input logic r1, input logic w0, input logic w1,
                       input logic [15:0] a0, input logic [15:0] a1,
                       input logic [15:0] d0, input logic [15:0] d1);
    req0 = r0; we0 = w0; adr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; adr1 = a1; wdata1 = d1;
    tick(1);
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    tick(n);
    reset = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    rd_hold[0] = '0;
    rd_hold[1] = '0;
  endtask

  task automatic test_reset();
    int en0;
    apply_reset(2);
    en0 = en_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({busy0, busy1, ack0, ack1, io_en, io_memwrite, io_memread} !== 7'b0) begin
        bad++;
        $display("FAIL reset_ctrl: got %b required 0000000",
                 {busy0, busy1, ack0, ack1, io_en, io_memwrite, io_memread});
      end
      total++;
      if ({io_adr, io_writedata, rdata0, rdata1} !== 64'h0) begin
        bad++;
        $display("FAIL reset_data: got %h required 0", {io_adr, io_writedata, rdata0, rdata1});
      end
    end
    tick(1);
    total++;
    if (en_cnt !== en0) begin
      bad++;
      $display("FAIL idle_en: io_en pulses %0d required 0", en_cnt - en0);
    end
  endtask

  task automatic test_port0_read();
    int t, tgt;
    clear_log();
    t = cyc;
    expect_txn(0, 1'b0, 16'h0005, 16'h0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 16'h0005, 16'h0, 16'h0, 16'h0);
    tgt = ack0_cnt + 1;
    for (int i = 0; i < 20 && ack0_cnt < tgt; i++) tick(1);
    total++;
    if (ack0_cnt !== tgt) begin
      bad++;
      $display("FAIL p0_read_timeout: acks %0d required %0d", ack0_cnt, tgt);
    end
    total++;
    if (en_cyc_log.size() !== 1) begin
      bad++;
      $display("FAIL p0_read_issues: got %0d required 1", en_cyc_log.size());
    end else begin
      total++;
      if ({en_cyc_log[0] - t, en_adr_log[0], 7'b0, en_we_log[0]} !== {32'd2, 16'h0005, 8'h00}) begin
        bad++;
        $display("FAIL p0_read_issue: offset=%0d adr=%h we=%b required 2/0005/0",
                 en_cyc_log[0] - t, en_adr_log[0], en_we_log[0]);
      end
    end
    total++;
    if (ack0_cyc - t !== 4) begin
      bad++;
      $display("FAIL p0_read_latency: ack at T+%0d required T+4", ack0_cyc - t);
    end
    tick(1);
    total++;
    if (busy0 !== 1'b0) begin
      bad++;
      $display("FAIL p0_busy_fall: busy0=%b required 0", busy0);
    end
  endtask

  task automatic test_port1_write();
    int t, tgt;
    clear_log();
    t = cyc;
    expect_txn(1, 1'b1, 16'h0012, 16'h0001);
    pulse(1'b0, 1'b1, 1'b0, 1'b1, 16'h0, 16'h0012, 16'h0, 16'h0001);
    tgt = ack1_cnt + 1;
    for (int i = 0; i < 20 && ack1_cnt < tgt; i++) tick(1);
    total++;
    if (ack1_cnt !== tgt) begin
      bad++;
      $display("FAIL p1_write_timeout: acks %0d required %0d", ack1_cnt, tgt);
    end
    total++;
    if (en_cyc_log.size() !== 1) begin
      bad++;
      $display("FAIL p1_write_issues: got %0d required 1", en_cyc_log.size());
    end else begin
      total++;
      if ({en_cyc_log[0] - t, en_adr_log[0], en_wd_log[0], en_we_log[0]} !==
          {32'd2, 16'h0012, 16'h0001, 1'b1}) begin
        bad++;
        $display("FAIL p1_write_issue: offset=%0d adr=%h wd=%h we=%b required 2/0012/0001/1",
                 en_cyc_log[0] - t, en_adr_log[0], en_wd_log[0], en_we_log[0]);
      end
    end
    total++;
    if (ack1_cyc - t !== 4) begin
      bad++;
      $display("FAIL p1_write_latency: ack at T+%0d required T+4", ack1_cyc - t);
    end
    total++;
    if (io_bits[18] !== 1'b1) begin
      bad++;
      $display("FAIL p1_write_bit18: got %b required 1", io_bits[18]);
    end
  endtask

  task automatic test_contention();
    int t, tgt0, tgt1;
    apply_reset(1);
    for (int round = 0; round < 2; round++) begin
      clear_log();
      t = cyc;
      expect_txn(0, 1'b0, 16'h0005, 16'h0);
      expect_txn(1, 1'b0, 16'h0012, 16'h0);
      pulse(1'b1, 1'b1, 1'b0, 1'b0, 16'h0005, 16'h0012, 16'h0, 16'h0);
      tgt0 = ack0_cnt + 1;
      tgt1 = ack1_cnt + 1;
      for (int i = 0; i < 30 && (ack0_cnt < tgt0 || ack1_cnt < tgt1); i++) tick(1);
      total++;
      if (ack0_cnt !== tgt0 || ack1_cnt !== tgt1) begin
        bad++;
        $display("FAIL tie_timeout: round %0d acks %0d/%0d required %0d/%0d",
                 round, ack0_cnt, ack1_cnt, tgt0, tgt1);
      end
      total++;
      if ({ack0_cyc - t, ack1_cyc - t} !== {32'd4, 32'd8}) begin
        bad++;
        $display("FAIL tie_latency: round %0d ack0 T+%0d ack1 T+%0d required T+4 T+8",
                 round, ack0_cyc - t, ack1_cyc - t);
      end
      total++;
      if (en_adr_log.size() !== 2) begin
        bad++;
        $display("FAIL tie_issues: round %0d got %0d required 2", round, en_adr_log.size());
      end else begin
        total++;
        if ({en_adr_log[0], en_adr_log[1], en_cyc_log[1] - t} !== {16'h0005, 16'h0012, 32'd6}) begin
          bad++;
          $display("FAIL tie_order: round %0d adr %h,%h second at T+%0d required 0005,0012 T+6",
                   round, en_adr_log[0], en_adr_log[1], en_cyc_log[1] - t);
        end
      end
      tick(2);
    end
  endtask

  task automatic test_rerequest();
    int t, a0;
    clear_log();
    a0 = ack0_cnt;
    t = cyc;
    expect_txn(0, 1'b0, 16'h0003, 16'h0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 16'h0003, 16'h0, 16'h0, 16'h0);
    tick(1);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 16'h0007, 16'h0, 16'h0, 16'h0);
    tick(12);
    total++;
    if (ack0_cnt - a0 !== 1) begin
      bad++;
      $display("FAIL rereq_acks: got %0d required 1", ack0_cnt - a0);
    end
    total++;
    if (en_adr_log.size() !== 1) begin
      bad++;
      $display("FAIL rereq_issues: got %0d required 1", en_adr_log.size());
    end else begin
      total++;
      if (en_adr_log[0] !== 16'h0003) begin
        bad++;
        $display("FAIL rereq_adr: got %h required 0003", en_adr_log[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int t, a0, a1, en0, tgt;
    a0 = ack0_cnt;
    a1 = ack1_cnt;
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 16'h0005, 16'h0, 16'h0, 16'h0);
    pulse(1'b0, 1'b1, 1'b0, 1'b1, 16'h0, 16'h0009, 16'h0, 16'h0001);
    tick(1);
    apply_reset(1);
    en0 = en_cnt;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if ({io_en, busy0, busy1, ack0, ack1} !== 5'b0) begin
        bad++;
        $display("FAIL midreset_ctrl: io_en/busy0/busy1/ack0/ack1=%b required 00000",
                 {io_en, busy0, busy1, ack0, ack1});
      end
    end
    tick(1);
    total++;
    if ({ack0_cnt - a0, ack1_cnt - a1, en_cnt - en0} !== {32'd0, 32'd0, 32'd0}) begin
      bad++;
      $display("FAIL midreset_quiet: acks %0d/%0d issues %0d required 0/0/0",
               ack0_cnt - a0, ack1_cnt - a1, en_cnt - en0);
    end
    total++;
    if (rdata0 !== 16'h0) begin
      bad++;
      $display("FAIL midreset_rdata0: got %h required 0000", rdata0);
    end
    clear_log();
    t = cyc;
    expect_txn(1, 1'b1, 16'h0009, 16'h0001);
    pulse(1'b0, 1'b1, 1'b0, 1'b1, 16'h0, 16'h0009, 16'h0, 16'h0001);
    tgt = ack1_cnt + 1;
    for (int i = 0; i < 20 && ack1_cnt < tgt; i++) tick(1);
    total++;
    if (ack1_cnt !== tgt || ack1_cyc - t !== 4) begin
      bad++;
      $display("FAIL midreset_fresh: acks %0d at T+%0d required %0d at T+4",
               ack1_cnt, ack1_cyc - t, tgt);
    end
    total++;
    if (io_bits[9] !== 1'b1) begin
      bad++;
      $display("FAIL midreset_bit9: got %b required 1", io_bits[9]);
    end
  endtask

  initial begin
    rd_hold[0] = '0;
    rd_hold[1] = '0;
    tick(1);
    test_reset();
    test_port0_read();
    test_port1_write();
    test_contention();
    test_rerequest();
    test_reset_mid();
    tick(2);
    total++;
    if (exp_q0.size() + exp_q1.size() !== 0) begin
      bad++;
      $display("FAIL leftover: %0d/%0d expected acks never arrived", exp_q0.size(), exp_q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
